pll_reset_sequencer: RTL



---
 rtl/pll_rst_seq_pkg.sv | 27 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 35 +++
 rtl/pll_reset_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pll_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_seq_pkg
// Shared definitions for the PLL reset sequencer: the FSM state encoding,
// the default cycle constants and a saturating 8-bit increment used by the
// status counters.
// ---------------------------------------------------------------------------
package pll_rst_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_HOLD_CYCLES         = 64;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_CNT_W               = 20;

    // Status counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for signals asynchronous to clk.
// Both stages clear to 0 under the asynchronous active-high reset.
// Ports:
//   clk    : destination clock
//   rst    : asynchronous active-high reset
//   i_d    : asynchronous input
//   o_q    : synchronised output (2 clk of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Drives the PLL reset from the free-running reference clock and produces a
// debounced, held system reset once the PLL lock has been stable long enough.
//
// Optional feature (macro PLL_RST_SEQ_LOCK_TIMEOUT_EN): while waiting for
// lock, a timeout counter re-kicks the PLL with a fresh pll_rst pulse and
// counts the retries in retry_cnt. Without the macro, WAIT_LOCK waits forever
// and retry_cnt is tied to 0.
//
// Ports:
//   clk           : 50 MHz free-running reference clock
//   rst           : asynchronous active-high reset
//   locked        : PLL lock, asynchronous to clk
//   pll_rst       : active-high reset to the PLL
//   sys_rst       : active-high reset for logic on the PLL output clock
//   ready         : high while in RUN
//   lock_lost_cnt : saturating count of lock losses seen in RUN
//   retry_cnt     : saturating count of timeout-driven PLL re-kicks
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int HOLD_CYCLES         = DEF_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_lost_cnt,
    output logic [7:0] retry_cnt
);

    // Counters must never reach a value they cannot represent.
    if ((PLL_RST_CYCLES < 1) || (LOCK_STABLE_CYCLES < 1) || (HOLD_CYCLES < 1) ||
        (LOCK_TIMEOUT_CYCLES < 1) ||
        (longint'(PLL_RST_CYCLES)      >= (longint'(1) << CNT_W)) ||
        (longint'(LOCK_STABLE_CYCLES)  >= (longint'(1) << CNT_W)) ||
        (longint'(HOLD_CYCLES)         >= (longint'(1) << CNT_W)) ||
        (longint'(LOCK_TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_cfg_invalid
        $error("pll_reset_sequencer: cycle parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] C_PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_lock_lost_cnt;
    logic [7:0]       w_lock_lost_nxt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             w_pll_rst_d;
    logic             w_sys_rst_d;
    logic             w_ready_d;
    logic             w_locked_s;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] w_tmo_nxt;
    logic [7:0]       r_retry_cnt;
    logic [7:0]       w_retry_nxt;
`endif

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_locked_s)
    );

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= PLL_RST;
            r_cnt           <= '0;
            r_lock_lost_cnt <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_rst       <= 1'b1;
            r_ready         <= 1'b0;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
            r_tmo           <= '0;
            r_retry_cnt     <= '0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_lock_lost_cnt <= w_lock_lost_nxt;
            r_pll_rst       <= w_pll_rst_d;
            r_sys_rst       <= w_sys_rst_d;
            r_ready         <= w_ready_d;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
            r_tmo           <= w_tmo_nxt;
            r_retry_cnt     <= w_retry_nxt;
`endif
        end
    end

    // Next-state and counter logic. The shared counter is cleared on every
    // state change so each state starts counting from 0.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_lost_nxt = r_lock_lost_cnt;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
        w_tmo_nxt       = '0;
        w_retry_nxt     = r_retry_cnt;
`endif
        case (r_state)
            PLL_RST: begin
                if (r_cnt == C_PLL_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            WAIT_LOCK: begin
                if (!w_locked_s) begin
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LOCK_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
                // A stable-count completion this cycle beats the timeout.
                if (w_state_nxt == WAIT_LOCK) begin
                    if (r_tmo == C_TMO_LAST) begin
                        w_state_nxt = PLL_RST;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = sat_inc8(r_retry_cnt);
                    end else begin
                        w_tmo_nxt   = r_tmo + C_ONE;
                    end
                end
`endif
            end
            HOLD: begin
                // A lock drop beats hold completion on the same cycle.
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt     = WAIT_LOCK;
                    w_cnt_nxt       = '0;
                    w_lock_lost_nxt = sat_inc8(r_lock_lost_cnt);
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state register.
    always_comb begin
        w_pll_rst_d = (w_state_nxt == PLL_RST);
        w_sys_rst_d = (w_state_nxt != RUN);
        w_ready_d   = (w_state_nxt == RUN);
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign lock_lost_cnt = r_lock_lost_cnt;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    assign retry_cnt     = r_retry_cnt;
`else
    assign retry_cnt     = 8'd0;
`endif

endmodule
